// File: rtl/display_pkg.sv
// Shared display definitions for the HEX0-HEX5 digit feeders.
package display_pkg;

    localparam int NUM_DIGITS = 6;

    typedef logic [3:0] nibble_t;

    localparam logic [NUM_DIGITS-1:0] DP_OFF   = 6'b111111;
    // Page 1 lights digit 0's decimal point so the viewer knows which half is shown.
    localparam logic [NUM_DIGITS-1:0] DP_PAGE1 = 6'b111110;

    typedef struct packed {
        nibble_t [NUM_DIGITS-1:0] digits;
        logic    [NUM_DIGITS-1:0] blank;
        logic    [NUM_DIGITS-1:0] dp_n;
    } disp_t;

    // Leading-zero mask: walk from the top digit down while the nibble is zero.
    // Digit 0 is never blanked so a zero value still shows "0".
    function automatic logic [NUM_DIGITS-1:0] lz_blank_mask(
        input nibble_t [NUM_DIGITS-1:0] nibs,
        input logic                     en
    );
        logic [NUM_DIGITS-1:0] m;
        logic                  run;
        m   = '0;
        run = en;
        for (int k = NUM_DIGITS-1; k >= 1; k--) begin
            if (run && nibs[k] == 4'h0) m[k] = 1'b1;
            else                        run  = 1'b0;
        end
        return m;
    endfunction

endpackage

// File: rtl/hex_word_pager_if.sv
// Word capture handshake between a debug source and the pager.
interface hex_word_pager_if;
    logic [31:0] word_in;
    logic        word_valid;
    logic        word_ready;

    modport master (output word_in, word_valid, input word_ready);
    modport slave  (input word_in, word_valid, output word_ready);
endinterface

// File: rtl/key_debouncer.sv
// Synchronizer + debouncer for an active-low push-button; emits a one-cycle press pulse.
module key_debouncer #(
    parameter int DEB_CYCLES = 500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_n,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic          meta;
    logic          sync;
    logic [CW-1:0] cnt;
    logic          settled;

    // Last cycle of the required run of differing samples.
    assign settled = (cnt == CW'(DEB_CYCLES - 1));

    // Two-flop synchronizer; reset to released (high).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            sync <= 1'b1;
        end else begin
            meta <= raw_n;
            sync <= meta;
        end
    end

    // Debounce: follow sync only after it disagrees for DEB_CYCLES consecutive cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= 1'b1;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            if (sync == level) begin
                cnt <= '0;
            end else if (settled) begin
                level <= sync;
                cnt   <= '0;
                // Only a falling level (currently high) counts as a press.
                press <= level;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/hex_word_pager.sv
// Captures a 32-bit debug word and pages it onto six hex digits (low 24 / high 8 bits).
module hex_word_pager
    import display_pkg::*;
#(
    parameter int CLK_HZ      = 50_000_000,
    parameter int PAGE_MS     = 1000,
    parameter int DEBOUNCE_MS = 10,
    parameter int LZ_BLANK    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    hex_word_pager_if.slave       bus,
    input  logic                  freeze,
    input  logic                  page_btn,
    input  logic                  auto_en,
    output logic [23:0]           digits,
    output logic [NUM_DIGITS-1:0] blank,
    output logic [NUM_DIGITS-1:0] dp_n,
    output logic                  page
);

    localparam int PAGE_CYCLES = CLK_HZ / 1000 * PAGE_MS;
    localparam int DEB_CYCLES  = CLK_HZ / 1000 * DEBOUNCE_MS;
    localparam int TW          = $clog2(PAGE_CYCLES + 1);
    localparam bit LZ_ON       = (LZ_BLANK != 0);
    // Reset display matches held=0 on page 0.
    localparam logic [NUM_DIGITS-1:0] RST_BLANK = LZ_ON ? 6'b111110 : 6'b000000;

    logic [31:0]   held;
    logic [TW-1:0] tcnt;
    logic          press;
    logic          btn_level_unused;
    logic          expire;
    logic          flip;
    disp_t         disp_d;
    disp_t         disp_q;

    assign bus.word_ready = !freeze;

    // Hold the most recently accepted word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                           held <= '0;
        else if (bus.word_valid && !freeze)   held <= bus.word_in;
    end

    key_debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_page_key (
        .clk   (clk),
        .rst_n (rst_n),
        .raw_n (page_btn),
        .level (btn_level_unused),
        .press (press)
    );

    assign expire = auto_en && (tcnt == TW'(PAGE_CYCLES - 1));
    // A press and an expiry in the same cycle still give a single flip.
    assign flip   = press || expire;

    // Auto-rotate timer and page register; a press restarts the interval.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt <= '0;
            page <= 1'b0;
        end else begin
            if (!auto_en || flip) tcnt <= '0;
            else                  tcnt <= tcnt + TW'(1);
            if (flip) page <= ~page;
        end
    end

    // Next display image from the current word and page.
    always_comb begin
        disp_d = '{digits: '0, blank: '0, dp_n: DP_OFF};
        if (!page) begin
            disp_d.digits = held[23:0];
            disp_d.blank  = lz_blank_mask(held[23:0], LZ_ON && (held[31:24] == 8'h00));
            disp_d.dp_n   = DP_OFF;
        end else begin
            disp_d.digits = {16'h0000, held[31:24]};
            // Digits 5..2 are always dark on page 1; digit 1 follows the zero rule.
            disp_d.blank  = 6'b111100 | lz_blank_mask({16'h0000, held[31:24]}, LZ_ON);
            disp_d.dp_n   = DP_PAGE1;
        end
    end

    // Registered display outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) disp_q <= '{digits: '0, blank: RST_BLANK, dp_n: DP_OFF};
        else        disp_q <= disp_d;
    end

    assign digits = disp_q.digits;
    assign blank  = disp_q.blank;
    assign dp_n   = disp_q.dp_n;

endmodule

// File: tb/tb_hex_word_pager.sv
// Directed bench for hex_word_pager: vector table plus hand-timed paging/reset sequences.
module tb_hex_word_pager;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        freeze = 1'b0;
    logic        page_btn = 1'b1;
    logic        auto_en = 1'b0;
    logic [23:0] digits;
    logic [5:0]  blank;
    logic [5:0]  dp_n;
    logic        page;

    int   errors = 0;
    int   checks = 0;
    logic exp_pg = 1'b0;

    typedef struct {
        logic [31:0] word;
        logic        pg;
        logic [23:0] digits;
        logic [5:0]  blank;
        logic [5:0]  dp_n;
    } vec_t;

    vec_t vecs [10];

    hex_word_pager_if bus ();

    hex_word_pager #(
        .CLK_HZ(1000), .PAGE_MS(10), .DEBOUNCE_MS(2), .LZ_BLANK(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .freeze(freeze), .page_btn(page_btn),
        .auto_en(auto_en), .digits(digits), .blank(blank), .dp_n(dp_n), .page(page)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Word accepted at the next edge; returns one edge later when outputs reflect it.
    task automatic capture(input logic [31:0] w);
        bus.word_in    = w;
        bus.word_valid = 1'b1;
        @(negedge clk);
        bus.word_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic press_btn();
        page_btn = 1'b0;
        repeat (5) @(negedge clk);
        page_btn = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic set_page(input logic p);
        if (exp_pg != p) begin
            press_btn();
            exp_pg = p;
        end
    endtask

    initial begin
        vecs[0] = '{32'h0000_00A5, 1'b0, 24'h0000A5, 6'b111100, 6'b111111};
        vecs[1] = '{32'h1200_0034, 1'b1, 24'h000012, 6'b111100, 6'b111110};
        vecs[2] = '{32'h1200_0034, 1'b0, 24'h000034, 6'b000000, 6'b111111};
        vecs[3] = '{32'h0000_0000, 1'b0, 24'h000000, 6'b111110, 6'b111111};
        vecs[4] = '{32'h00F0_0000, 1'b0, 24'hF00000, 6'b000000, 6'b111111};
        vecs[5] = '{32'h0000_1000, 1'b0, 24'h001000, 6'b110000, 6'b111111};
        vecs[6] = '{32'h0500_0000, 1'b1, 24'h000005, 6'b111110, 6'b111110};
        vecs[7] = '{32'h0500_0000, 1'b0, 24'h000000, 6'b000000, 6'b111111};
        vecs[8] = '{32'hFFFF_FFFF, 1'b1, 24'h0000FF, 6'b111100, 6'b111110};
        vecs[9] = '{32'h0000_0000, 1'b1, 24'h000000, 6'b111110, 6'b111110};

        bus.word_in    = '0;
        bus.word_valid = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_digits", digits, 24'h0);
        chk("rst_blank",  blank,  6'b111110);
        chk("rst_dp",     dp_n,   6'b111111);
        chk("rst_page",   page,   1'b0);
        chk("rst_ready",  bus.word_ready, 1'b1);
        rst_n = 1'b1;
        @(negedge clk);

        // Vector table
        for (int i = 0; i < 10; i++) begin
            set_page(vecs[i].pg);
            capture(vecs[i].word);
            chk($sformatf("v%0d_digits", i), digits, vecs[i].digits);
            chk($sformatf("v%0d_blank", i),  blank,  vecs[i].blank);
            chk($sformatf("v%0d_dp", i),     dp_n,   vecs[i].dp_n);
            chk($sformatf("v%0d_page", i),   page,   exp_pg);
        end

        // Exact button latency: flip at E+4, outputs at E+5
        page_btn = 1'b0;
        repeat (4) @(negedge clk);
        chk("btn_early", page, exp_pg);
        @(negedge clk);
        exp_pg = ~exp_pg;
        chk("btn_flip", page, exp_pg);
        chk("btn_dp_lag", dp_n, 6'b111110);
        @(negedge clk);
        chk("btn_dp_new", dp_n, 6'b111111);
        page_btn = 1'b1;
        repeat (8) @(negedge clk);
        chk("btn_release", page, exp_pg);

        // One-cycle glitch gives no press
        page_btn = 1'b0;
        @(negedge clk);
        page_btn = 1'b1;
        repeat (10) @(negedge clk);
        chk("glitch_page", page, exp_pg);

        // Freeze ignores capture
        capture(32'h1234_5678);
        chk("pre_freeze", digits, 24'h345678);
        freeze = 1'b1;
        @(negedge clk);
        chk("frz_ready", bus.word_ready, 1'b0);
        bus.word_in    = 32'hDEAD_BEEF;
        bus.word_valid = 1'b1;
        @(negedge clk);
        bus.word_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("frz_lo", digits, 24'h345678);
        set_page(1'b1);
        chk("frz_hi", digits, 24'h000012);
        freeze = 1'b0;
        @(negedge clk);
        chk("unfrz_ready", bus.word_ready, 1'b1);
        set_page(1'b0);

        // Auto-rotate; then a press landing on the expiry cycle
        auto_en = 1'b1;
        repeat (9) @(negedge clk);
        chk("auto_pre", page, exp_pg);
        @(negedge clk);
        exp_pg = ~exp_pg;
        chk("auto_flip1", page, exp_pg);
        repeat (5) @(negedge clk);
        page_btn = 1'b0;
        repeat (4) @(negedge clk);
        chk("coinc_pre", page, exp_pg);
        @(negedge clk);
        exp_pg = ~exp_pg;
        chk("coinc_once", page, exp_pg);
        page_btn = 1'b1;
        repeat (9) @(negedge clk);
        chk("coinc_hold", page, exp_pg);
        @(negedge clk);
        exp_pg = ~exp_pg;
        chk("auto_flip3", page, exp_pg);
        auto_en = 1'b0;
        repeat (2) @(negedge clk);

        // Reset in the middle of a debounce while on page 1
        set_page(1'b1);
        page_btn = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        exp_pg = 1'b0;
        chk("arst_page",   page,   1'b0);
        chk("arst_blank",  blank,  6'b111110);
        chk("arst_digits", digits, 24'h0);
        chk("arst_dp",     dp_n,   6'b111111);
        page_btn = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("post_rst_page", page, exp_pg);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
